// File: rtl/npu_argmax_unit_if.sv
// npu_argmax_unit_if
//   Port-B connection between the argmax unit and the shared NPU/CPU score
//   memory.
//   master : argmax side. Drives address, write enable and write data; receives read data.
//   slave  : memory side.
//   mem_addr_o   [12:0] port-B address
//   mem_wr_o            port-B write enable (the argmax unit never writes)
//   mem_wrdata_o [7:0]  port-B write data
//   mem_rddata_i [7:0]  port-B read data, RD_LAT cycles after the address
interface npu_argmax_unit_if;
  logic [12:0] mem_addr_o;
  logic        mem_wr_o;
  logic [7:0]  mem_wrdata_o;
  logic [7:0]  mem_rddata_i;

  modport master (
    output mem_addr_o,
    output mem_wr_o,
    output mem_wrdata_o,
    input  mem_rddata_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wr_o,
    input  mem_wrdata_o,
    output mem_rddata_i
  );
endinterface

// File: rtl/npu_argmax_unit.sv
// npu_argmax_unit
//   Classification back-end. The unit scans NUM_CLASSES score bytes through
//   memory port B, starting at base_addr, and reports the index and value of
//   the largest score. On a tie, the lowest index wins.
//   Optional macro NPU_ARGMAX_SIGNED_EN: compare scores as int8. When the
//   macro is undefined, scores are compared as unsigned bytes.
// Parameters
//   NUM_CLASSES : number of scores to scan (2..32)
//   RD_LAT      : port-B read latency in cycles (1..3)
// Ports
//   clk, resetn : clock, asynchronous active-low reset
//   mem         : port-B bus (master modport)
//   start       : single-cycle scan request, honoured in IDLE/DONE only
//   abort       : return to IDLE at once; wins over start
//   base_addr   : address of class 0 score, sampled with start
//   busy        : high while in ISSUE or DRAIN
//   done        : high while in DONE
//   class_o     : winning class index
//   max_score_o : winning score
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one address per cycle, base+0 .. base+NUM_CLASSES-1
// DRAIN | all addresses issued, waiting for outstanding reads to be compared
// DONE  | result valid, done high until next start/abort
module npu_argmax_unit #(
  parameter int NUM_CLASSES = 24,
  parameter int RD_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  npu_argmax_unit_if.master         mem,
  input  logic                      start,
  input  logic                      abort,
  input  logic [12:0]               base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [4:0]                class_o,
  output logic [7:0]                max_score_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_CLASSES - 1);

  state_t            state;
  logic [4:0]        issue_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic              rd_v;
  logic [7:0]        rd_q;
  logic [4:0]        cmp_idx;
  logic              first;
  logic [7:0]        run_max;
  logic [4:0]        run_idx;

  logic              take_new;
  logic [7:0]        win_score;
  logic [4:0]        win_idx;
  logic              last_cmp;

  function automatic logic score_gt(input logic [7:0] a, input logic [7:0] b);
`ifdef NPU_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign mem.mem_wr_o     = 1'b0;
  assign mem.mem_wrdata_o = 8'h00;

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    take_new  = first | score_gt(rd_q, run_max);
    win_score = take_new ? rd_q : run_max;
    win_idx   = take_new ? cmp_idx : run_idx;
    last_cmp  = rd_v && (cmp_idx == LAST_IDX);
  end

  // Read data is registered once (rd_q) before the compare. That extra
  // stage sets done at start + NUM_CLASSES + RD_LAT + 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      mem.mem_addr_o <= '0;
      issue_cnt      <= '0;
      vld_pipe       <= '0;
      rd_v           <= 1'b0;
      rd_q           <= '0;
      cmp_idx        <= '0;
      first          <= 1'b0;
      run_max        <= '0;
      run_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      class_o        <= '0;
      max_score_o    <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      vld_pipe <= '0;
      rd_v     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LAT'(state == S_ISSUE);
      rd_v     <= vld_pipe[RD_LAT-1];
      if (vld_pipe[RD_LAT-1]) begin
        rd_q <= mem.mem_rddata_i;
      end
      if (rd_v) begin
        run_max <= win_score;
        run_idx <= win_idx;
        first   <= 1'b0;
        cmp_idx <= cmp_idx + 5'd1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_ISSUE;
            mem.mem_addr_o <= base_addr;
            issue_cnt      <= '0;
            cmp_idx        <= '0;
            first          <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (issue_cnt == LAST_IDX) begin
            state <= S_DRAIN;
          end else begin
            mem.mem_addr_o <= mem.mem_addr_o + 13'd1;
            issue_cnt      <= issue_cnt + 5'd1;
          end
        end
        S_DRAIN: begin
          if (last_cmp) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            class_o     <= win_idx;
            max_score_o <= win_score;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
